// File: rtl/raster_ctx_source_if.sv
// Pixel-group stream bus for raster_ctx_source.
//   i_valid/i_ready : input beat handshake; i_b = above-row group, i_x = current group
//   o_valid/o_ready : output beat handshake; o_b = above context (LANES+2 lanes), o_x = current group
//   o_sl/o_sp/o_ep/o_ef : line-0, start-of-line, end-of-line, end-of-frame tags
// Handshake: a beat moves on a rising clk edge where valid && ready are both high;
// the source keeps valid and data stable until that edge, and ready never depends on valid.
// Lane j of a packed group sits at bits [j*BW +: BW].
interface raster_ctx_source_if #(
  parameter int LANES = 8,
  parameter int BW    = 8
);
  logic                      i_valid;
  logic                      i_ready;
  logic [LANES*BW-1:0]       i_b;
  logic [LANES*BW-1:0]       i_x;
  logic                      o_valid;
  logic                      o_ready;
  logic                      o_sl;
  logic                      o_sp;
  logic                      o_ep;
  logic                      o_ef;
  logic [(LANES+2)*BW-1:0]   o_b;
  logic [LANES*BW-1:0]       o_x;

  modport master (
    output i_valid, i_b, i_x, o_ready,
    input  i_ready, o_valid, o_sl, o_sp, o_ep, o_ef, o_b, o_x
  );

  modport slave (
    input  i_valid, i_b, i_x, o_ready,
    output i_ready, o_valid, o_sl, o_sp, o_ep, o_ef, o_b, o_x
  );
endinterface

// File: rtl/raster_ctx_source.sv
// Raster context source for the JPEG-LS encoder front end.
// Takes LANES-pixel groups with their above-row groups, tags them with line/frame
// flags and appends two lookahead above-pixels taken from the following group
// (or synthesised at line end).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : frame start pulse (ignored while busy or when height==0)
//   width, height   : beats per line minus 1, lines per frame; latched on start
//   busy            : frame in progress
//   state_dbg       : current FSM state (0 idle, 1 run, 2 drain)
//   bus             : stream bus, slave side (see raster_ctx_source_if)
module raster_ctx_source #(
  parameter int LANES = 8,
  parameter int BW    = 8,
  parameter int WBITS = 10,
  parameter int HBITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WBITS-1:0]  width,
  input  logic [HBITS-1:0]  height,
  output logic              busy,
  output logic [1:0]        state_dbg,
  raster_ctx_source_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          state;
  logic [WBITS-1:0]    width_q;
  logic [WBITS-1:0]    hpos;
  logic [HBITS-1:0]    height_q;
  logic [HBITS-1:0]    vpos;

  // Hold slot H: a beat waits here until its lookahead source is known.
  logic                h_full;
  logic                h_sl;
  logic                h_sp;
  logic                h_ep;
  logic                h_ef;
  logic [LANES*BW-1:0] h_b;
  logic [LANES*BW-1:0] h_x;

  logic                ocl;
  logic                accept;
  logic                h_to_o;
  logic                start_ok;
  logic                in_sl;
  logic                in_sp;
  logic                in_ep;
  logic                in_ef;
  logic [LANES*BW-1:0] in_b;
  logic [2*BW-1:0]     look;

  assign busy         = (state != S_IDLE);
  assign state_dbg    = state;
  assign bus.i_ready  = (state == S_RUN) && (!h_full || ocl);

  always_comb begin
    ocl      = !bus.o_valid || bus.o_ready;
    accept   = bus.i_valid && bus.i_ready;
    // A non-end beat needs its successor's above lanes; a line-end beat does not.
    h_to_o   = ocl && h_full && (h_ep || accept);
    start_ok = (state == S_IDLE) && start && (height != '0);
    in_sl    = (vpos == '0);
    in_sp    = (hpos == '0);
    in_ep    = (hpos == width_q);
    in_ef    = in_ep && (vpos == height_q - HBITS'(1));
    in_b     = in_sl ? '0 : bus.i_b;
    // look[BW-1:0] becomes lane LANES, look[2*BW-1:BW] lane LANES+1.
    if (!h_ep) begin
      look = in_b[2*BW-1:0];
    end else if (!h_sl) begin
      look = {~h_b[(LANES-1)*BW +: BW], h_b[(LANES-1)*BW +: BW]};
    end else begin
      look = {{(BW-1){1'b0}}, 1'b1, {BW{1'b0}}};
    end
  end

  // Frame control and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      width_q  <= '0;
      height_q <= '0;
      hpos     <= '0;
      vpos     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state    <= S_RUN;
            width_q  <= width;
            height_q <= height;
          end
        end
        S_RUN: begin
          if (accept && in_ef) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (bus.o_valid && bus.o_ready && bus.o_ef) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (start_ok) begin
        hpos <= '0;
        vpos <= '0;
      end else if (accept) begin
        if (in_ep) begin
          hpos <= '0;
          vpos <= vpos + HBITS'(1);
        end else begin
          hpos <= hpos + WBITS'(1);
        end
      end
    end
  end

  // Hold slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_full <= 1'b0;
      h_sl   <= 1'b0;
      h_sp   <= 1'b0;
      h_ep   <= 1'b0;
      h_ef   <= 1'b0;
      h_b    <= '0;
      h_x    <= '0;
    end else if (accept) begin
      h_full <= 1'b1;
      h_sl   <= in_sl;
      h_sp   <= in_sp;
      h_ep   <= in_ep;
      h_ef   <= in_ef;
      h_b    <= in_b;
      h_x    <= bus.i_x;
    end else if (h_to_o) begin
      h_full <= 1'b0;
    end
  end

  // Output register; data only changes on a load, so it stays stable under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_valid <= 1'b0;
      bus.o_sl    <= 1'b0;
      bus.o_sp    <= 1'b0;
      bus.o_ep    <= 1'b0;
      bus.o_ef    <= 1'b0;
      bus.o_b     <= '0;
      bus.o_x     <= '0;
    end else if (h_to_o) begin
      bus.o_valid <= 1'b1;
      bus.o_sl    <= h_sl;
      bus.o_sp    <= h_sp;
      bus.o_ep    <= h_ep;
      bus.o_ef    <= h_ef;
      bus.o_b     <= {look, h_b};
      bus.o_x     <= h_x;
    end else if (bus.o_ready) begin
      bus.o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raster_ctx_source.sv
module tb_raster_ctx_source;
  localparam int L  = 8;
  localparam int BW = 8;
  localparam int WB = 10;
  localparam int HB = 16;
  localparam int W  = 4 + (L+2)*BW + L*BW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WB-1:0] width = '0;
  logic [HB-1:0] height = '0;
  logic          busy;
  logic [1:0]    state_dbg;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  raster_ctx_source_if #(.LANES(L), .BW(BW)) bus ();

  raster_ctx_source #(.LANES(L), .BW(BW), .WBITS(WB), .HBITS(HB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .width     (width),
    .height    (height),
    .busy      (busy),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int vectors = 0;
  int fails   = 0;

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.o_ready)
      obs_q.push_back({bus.o_ef, bus.o_ep, bus.o_sp, bus.o_sl, bus.o_b, bus.o_x});
  end

  function automatic logic [W-1:0] mk(input logic sl, sp, ep, ef,
                                      input logic [(L+2)*BW-1:0] b,
                                      input logic [L*BW-1:0] x);
    return {ef, ep, sp, sl, b, x};
  endfunction

  function automatic logic [L*BW-1:0] rep(input int k);
    logic [BW-1:0] v;
    v = BW'(k);
    return {L{v}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input int w, input int h);
    width  = WB'(w);
    height = HB'(h);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic drive_beat(input logic [L*BW-1:0] b, input logic [L*BW-1:0] x);
    int n;
    n = 0;
    bus.i_valid = 1'b1;
    bus.i_b     = b;
    bus.i_x     = x;
    @(negedge clk);
    while (!bus.i_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      fails++;
      $display("FAIL drive_timeout: i_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int c;
    c = 0;
    while (obs_q.size() < n && c < 300) begin
      @(negedge clk); #1;
      c++;
    end
    if (obs_q.size() < n) begin
      vectors++;
      fails++;
      $display("FAIL wait_out: got %0d beats, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({busy, bus.i_ready, bus.o_valid, bus.o_sl, bus.o_sp, bus.o_ep, bus.o_ef} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, bus.i_ready, bus.o_valid, bus.o_sl, bus.o_sp, bus.o_ep, bus.o_ef});
    end
    vectors++;
    if (bus.o_b !== '0 || bus.o_x !== '0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL reset_data: o_b=%h o_x=%h state=%0d required all 0", bus.o_b, bus.o_x, state_dbg);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // height==0 start is ignored
    do_start(3, 0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL start_h0: busy=%b state=%0d required 0/0", busy, state_dbg);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [L*BW-1:0]     ib;
    logic [(L+2)*BW-1:0] eb;
    int c0;
    obs_q.delete();
    exp_q.delete();
    do_start(1, 2);
    vectors++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    width  = WB'(7);
    height = HB'(9);
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < L; j++) ib[j*BW +: BW] = 8'h10 + 8'(j);
      if (k == 3) ib[7*BW +: BW] = 8'h5A;
      drive_beat(ib, rep(k));
    end
    vectors++;
    if (cyc - c0 !== 4) begin
      fails++;
      $display("FAIL basic_throughput: %0d cycles for 4 beats, required 4", cyc - c0);
    end
    wait_out(4);
    vectors++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_last: got %b required 1", busy);
    end
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_fall: got %b required 0", busy);
    end

    eb = '0;
    exp_q.push_back(mk(1, 1, 0, 0, eb, rep(0)));
    eb[9*BW +: BW] = 8'h01;
    exp_q.push_back(mk(1, 0, 1, 0, eb, rep(1)));
    for (int j = 0; j < L; j++) eb[j*BW +: BW] = 8'h10 + 8'(j);
    eb[8*BW +: BW] = 8'h10;
    eb[9*BW +: BW] = 8'h11;
    exp_q.push_back(mk(0, 1, 0, 0, eb, rep(2)));
    eb[7*BW +: BW] = 8'h5A;
    eb[8*BW +: BW] = 8'h5A;
    eb[9*BW +: BW] = 8'hA5;
    exp_q.push_back(mk(0, 0, 1, 1, eb, rep(3)));

    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL basic_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        fails++;
        $display("FAIL basic_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL basic_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [L*BW-1:0]     ib;
    logic [(L+2)*BW-1:0] eb;
    obs_q.delete();
    exp_q.delete();
    for (int j = 0; j < L; j++) ib[j*BW +: BW] = 8'h40 + 8'(j);
    do_start(1, 2);
    drive_beat(ib, rep(0));
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat_hold: o_valid=%b required 0 before successor", bus.o_valid);
    end
    @(posedge clk); #1;
    drive_beat(ib, rep(1));
    vectors++;
    if (bus.o_valid !== 1'b1 || bus.o_sp !== 1'b1 || bus.o_ep !== 1'b0) begin
      fails++;
      $display("FAIL lat_rise: valid/sp/ep=%b%b%b required 110", bus.o_valid, bus.o_sp, bus.o_ep);
    end
    // the line-end beat must come out without any next-line input
    wait_out(2);
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 2) begin
      fails++;
      $display("FAIL lat_line_end: got %0d beats, required 2", obs_q.size());
    end
    @(posedge clk); #1;
    drive_beat(ib, rep(2));
    drive_beat(ib, rep(3));
    wait_out(4);

    eb = '0;
    exp_q.push_back(mk(1, 1, 0, 0, eb, rep(0)));
    eb[9*BW +: BW] = 8'h01;
    exp_q.push_back(mk(1, 0, 1, 0, eb, rep(1)));
    for (int j = 0; j < L; j++) eb[j*BW +: BW] = 8'h40 + 8'(j);
    eb[8*BW +: BW] = 8'h40;
    eb[9*BW +: BW] = 8'h41;
    exp_q.push_back(mk(0, 1, 0, 0, eb, rep(2)));
    eb[8*BW +: BW] = 8'h47;
    eb[9*BW +: BW] = 8'hB8;
    exp_q.push_back(mk(0, 0, 1, 1, eb, rep(3)));

    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL lat_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        fails++;
        $display("FAIL lat_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL lat_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [L*BW-1:0]     ib;
    logic [(L+2)*BW-1:0] eb;
    logic [W:0]          snap;
    obs_q.delete();
    exp_q.delete();
    for (int j = 0; j < L; j++) ib[j*BW +: BW] = 8'h20 + 8'(j);
    do_start(3, 2);
    fork
      begin
        for (int k = 0; k < 8; k++) drive_beat(ib, rep(k));
      end
      begin
        wait_out(3);
        @(posedge clk); #1;
        bus.o_ready = 1'b0;
        @(negedge clk);
        snap = {bus.o_valid, bus.o_ef, bus.o_ep, bus.o_sp, bus.o_sl, bus.o_b, bus.o_x};
        vectors++;
        if (snap[W] !== 1'b1) begin
          fails++;
          $display("FAIL bp_valid: o_valid=%b required 1 during stall", snap[W]);
        end
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          vectors++;
          if ({bus.o_valid, bus.o_ef, bus.o_ep, bus.o_sp, bus.o_sl, bus.o_b, bus.o_x} !== snap) begin
            fails++;
            $display("FAIL bp_stable%0d: got %h required %h", s,
                     {bus.o_valid, bus.o_ef, bus.o_ep, bus.o_sp, bus.o_sl, bus.o_b, bus.o_x}, snap);
          end
        end
        vectors++;
        if (bus.i_ready !== 1'b0) begin
          fails++;
          $display("FAIL bp_iready: got %b required 0 with H and O full", bus.i_ready);
        end
        @(posedge clk); #1;
        bus.o_ready = 1'b1;
      end
    join
    wait_out(8);

    for (int k = 0; k < 8; k++) begin
      eb = '0;
      if (k >= 4) begin
        for (int j = 0; j < L; j++) eb[j*BW +: BW] = 8'h20 + 8'(j);
        eb[8*BW +: BW] = (k == 7) ? 8'h27 : 8'h20;
        eb[9*BW +: BW] = (k == 7) ? 8'hD8 : 8'h21;
      end else if (k == 3) begin
        eb[9*BW +: BW] = 8'h01;
      end
      exp_q.push_back(mk(k < 4, (k % 4) == 0, (k % 4) == 3, k == 7, eb, rep(k)));
    end

    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL bp_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        fails++;
        $display("FAIL bp_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL bp_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_single_beat_lines();
    logic [L*BW-1:0]     ib;
    logic [(L+2)*BW-1:0] eb;
    obs_q.delete();
    exp_q.delete();
    for (int j = 0; j < L; j++) ib[j*BW +: BW] = 8'h30 + 8'(j);
    do_start(0, 3);
    for (int k = 0; k < 3; k++) drive_beat(ib, rep(k));
    wait_out(3);
    vectors++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL w0_busy_last: got %b required 1", busy);
    end
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL w0_busy_fall: got %b required 0", busy);
    end

    eb = '0;
    eb[9*BW +: BW] = 8'h01;
    exp_q.push_back(mk(1, 1, 1, 0, eb, rep(0)));
    for (int j = 0; j < L; j++) eb[j*BW +: BW] = 8'h30 + 8'(j);
    eb[8*BW +: BW] = 8'h37;
    eb[9*BW +: BW] = 8'hC8;
    exp_q.push_back(mk(0, 1, 1, 0, eb, rep(1)));
    exp_q.push_back(mk(0, 1, 1, 1, eb, rep(2)));

    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL w0_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        fails++;
        $display("FAIL w0_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL w0_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    logic [L*BW-1:0]     ib;
    logic [(L+2)*BW-1:0] eb;
    for (int j = 0; j < L; j++) ib[j*BW +: BW] = 8'h50 + 8'(j);
    do_start(1, 2);
    for (int k = 0; k < 3; k++) drive_beat(ib, rep(k));
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.o_valid, busy, bus.i_ready} !== 3'b000 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL mid_rst: valid/busy/i_ready=%b state=%0d required 000/0",
               {bus.o_valid, busy, bus.i_ready}, state_dbg);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    for (int j = 0; j < L; j++) ib[j*BW +: BW] = 8'h60 + 8'(j);
    do_start(1, 1);
    drive_beat(ib, rep(7));
    drive_beat(ib, rep(8));
    wait_out(2);

    eb = '0;
    exp_q.push_back(mk(1, 1, 0, 0, eb, rep(7)));
    eb[9*BW +: BW] = 8'h01;
    exp_q.push_back(mk(1, 0, 1, 1, eb, rep(8)));

    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL rst_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        fails++;
        $display("FAIL rst_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rst_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    wait_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.i_valid = 1'b0;
    bus.i_b     = '0;
    bus.i_x     = '0;
    bus.o_ready = 1'b1;
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_single_beat_lines();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/raster_ctx_source.md
Name: raster_ctx_source

Overview:
- Parametrised successor of the pixel-group raster source in the JPEG-LS encoder front end.
- Accepts a stream of LANES-pixel groups, each with its matching above-row group from the external line buffer.
- Emits each group with line/frame flags and LANES+2 above-context pixels; the 2 lookahead pixels come from the next group, or are synthesised at line end.
- Adds valid/ready backpressure on both sides, a frame start/busy protocol and an end-of-frame flag.

Parameters:
- LANES, 8, pixels per beat (>=2)
- BW, 8, bits per pixel
- WBITS, 10, width of the beats-per-line field
- HBITS, 16, width of the line-count field

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  pulse; latches width/height and begins a frame; ignored while busy=1 or when height==0
- width  in  WBITS  beats per line minus 1 (line = width+1 beats); sampled on start
- height  in  HBITS  lines per frame; sampled on start
- busy  out  1  high from the cycle after an accepted start until the frame's last beat leaves the output register
- i_valid  in  1  input beat valid
- i_ready  out  1  input beat accepted when i_valid&&i_ready
- i_b  in  LANES*BW  above-row pixels; lane j at bits [j*BW +: BW]; ignored on line 0
- i_x  in  LANES*BW  current pixels, same packing
- o_valid  out  1  output beat valid
- o_ready  in  1  downstream accepts when o_valid&&o_ready
- o_sl  out  1  beat belongs to line 0
- o_sp  out  1  first beat of a line
- o_ep  out  1  last beat of a line
- o_ef  out  1  last beat of the frame (implies o_ep)
- o_b  out  (LANES+2)*BW  above context; lanes 0..LANES-1 = above group, lanes LANES, LANES+1 = lookahead
- o_x  out  LANES*BW  current pixels

Behaviour:
- Reset (async): busy, i_ready, o_valid and all flags = 0; o_b, o_x = 0; counters hpos/vpos = 0; hold slot H empty; state IDLE.
- States:
  - IDLE -> RUN on an accepted start.
  - RUN -> DRAIN when the frame's last input beat is accepted.
  - DRAIN -> IDLE when the final beat is taken from the output register O.
- Counters: hpos counts 0..width and advances on each accepted input beat; on wrap, hpos=0 and vpos+1. Both clear on start.
- Beat tagging at acceptance:
  - sl = (vpos==0); sp = (hpos==0); ep = (hpos==width); ef = ep && (vpos==height-1).
  - On line 0, the above group is forced to 0.
- Two-register pipeline: hold slot H, then output register O.
  - ocl = !o_valid || o_ready.
  - i_ready = (state==RUN) && (!H_full || ocl); combinational, no dependence on i_valid.
- H->O transfer happens when ocl and H_full and either:
  - H.ep=1, or
  - an input beat is accepted in the same cycle.
- Lookahead lanes written into O:
  - H.ep=0: lanes LANES, LANES+1 = incoming beat's above lanes 0,1 (zero on line 0).
  - H.ep=1, H.sl=0: lane LANES = H.b[LANES-1]; lane LANES+1 = ~H.b[LANES-1].
  - H.ep=1, H.sl=1: lane LANES = 0; lane LANES+1 = 1.
- Simultaneous transfer-and-accept: the new beat enters H in the same cycle, so sustained throughput is 1 beat/clk.
- Non-end beat latency: it stays in H until its successor arrives; o_valid rises the cycle after the successor is accepted.
- Line-end beat latency: it moves to O on the first cycle ocl=1 after entering H, without waiting for the next line.
- O holds o_* stable while o_valid && !o_ready.
- Width/height changes while busy have no effect.
- width==0 gives single-beat lines: every beat has sp=ep=1.
- Mid-frame rst: everything clears immediately; the partial frame is discarded.

Test Plan:
- LANES=8, BW=8, width=1, height=2, start, continuous valid/ready, i_b lanes = 0x10+j, i_x = beat index -> 4 outputs.
  - Flags: sl=1,1,0,0; sp=1,0,1,0; ep=0,1,0,1; ef only on beat 4.
  - o_b on line 0 all zero except beat 2 lane 9 = 0x01.
- Same frame, line 1 end beat with i_b lane 7 = 0x5A -> o_b lane 8 = 0x5A, lane 9 = 0xA5.
- Line 1 beat 0 -> o_b lanes 8,9 = next beat's i_b lanes 0,1 (0x10,0x11).
- o_ready held 0 for 5 cycles mid-frame -> o_* stable, i_ready low once H and O are full, no beat lost or duplicated, order preserved.
- width=0, height=3 -> 3 beats, each sp=ep=1, last with ef=1; busy falls the cycle after the third output handshake.
- rst asserted mid-line 1 -> o_valid, busy, i_ready = 0 the same cycle; a new start yields a clean frame with sl=1 on the first beat.
